// File: rtl/ift_pkg.sv
// rtl/ift_pkg.sv - shared IFT constants and taint label combine helper
package ift_pkg;

   localparam int DEFAULT_TAINT_WIDTH = 32;

   localparam int IFT_CONSERVATIVE = 0;
   localparam int IFT_PRECISE      = 1;

   // Labels from independent sources only ever merge; nothing subtracts a label.
   function automatic logic [DEFAULT_TAINT_WIDTH-1:0] taint_or(
      input logic [DEFAULT_TAINT_WIDTH-1:0] a,
      input logic [DEFAULT_TAINT_WIDTH-1:0] b
   );
      return a | b;
   endfunction

endpackage

// File: rtl/ift_taint_next.sv
// rtl/ift_taint_next.sv - next-state taint labels for the IFT flip-flop
module ift_taint_next
   import ift_pkg::*;
#(
   parameter int WIDTH       = 2,
   parameter int TAINT_WIDTH = DEFAULT_TAINT_WIDTH,
   parameter int PRECISE     = IFT_CONSERVATIVE
) (
   input  logic [WIDTH-1:0]       d_i,
   input  logic [WIDTH-1:0]       q_i,
   input  logic [TAINT_WIDTH-1:0] d_t_i,
   input  logic [TAINT_WIDTH-1:0] q_t_i,
   input  logic [TAINT_WIDTH-1:0] clk_t_i,
   input  logic [TAINT_WIDTH-1:0] rst_n_t_i,
   output logic [TAINT_WIDTH-1:0] q_t_d_o
);

   logic [TAINT_WIDTH-1:0] capture_t;

   always_comb begin
      capture_t = taint_or(taint_or(d_t_i, clk_t_i), rst_n_t_i);
      q_t_d_o   = capture_t;
      // An unknown comparison falls to the else path, i.e. treated as a change.
      if ((PRECISE == IFT_PRECISE) && (d_i == q_i)) begin
         q_t_d_o = taint_or(q_t_i, d_t_i);
      end else begin
         q_t_d_o = capture_t;
      end
   end

endmodule

// File: rtl/dff_ift.sv
// rtl/dff_ift.sv - rising-edge DFF with information-flow-tracking shadow register
module dff_ift
   import ift_pkg::*;
#(
   parameter int WIDTH       = 2,
   parameter int TAINT_WIDTH = DEFAULT_TAINT_WIDTH,
   parameter int PRECISE     = IFT_CONSERVATIVE
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [TAINT_WIDTH-1:0] CLK_t,
   input  logic [TAINT_WIDTH-1:0] RST_N_t,
   input  logic [WIDTH-1:0]       D,
   input  logic [TAINT_WIDTH-1:0] D_t,
   output logic [WIDTH-1:0]       Q,
   output logic [TAINT_WIDTH-1:0] Q_t
);

   logic [WIDTH-1:0]       q_q;
   logic [TAINT_WIDTH-1:0] q_t_q;
   logic [TAINT_WIDTH-1:0] q_t_d;

   ift_taint_next #(
      .WIDTH      (WIDTH),
      .TAINT_WIDTH(TAINT_WIDTH),
      .PRECISE    (PRECISE)
   ) u_taint_next (
      .d_i      (D),
      .q_i      (q_q),
      .d_t_i    (D_t),
      .q_t_i    (q_t_q),
      .clk_t_i  (CLK_t),
      .rst_n_t_i(RST_N_t),
      .q_t_d_o  (q_t_d)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q <= '0;
      end else begin
         q_q <= D;
      end
   end

   // The stored label keeps the last reset taint seen so it is still held after release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_t_q <= RST_N_t;
      end else begin
         q_t_q <= q_t_d;
      end
   end

   assign Q   = q_q;
   assign Q_t = RST_N ? q_t_q : RST_N_t;

endmodule

// File: tb/tb_dff_ift.sv
// tb/tb_dff_ift.sv - self-checking bench for dff_ift in both taint modes
module tb_dff_ift;

   typedef struct {
      logic [1:0]  d;
      logic [31:0] dt;
      logic [31:0] ct;
      logic [31:0] rt;
      logic [1:0]  eq;
      logic [31:0] eqt;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic [31:0] CLK_t = '0;
   logic [31:0] RST_N_t = '0;
   logic [1:0]  D = '0;
   logic [31:0] D_t = '0;
   logic [1:0]  q_c, q_p;
   logic [31:0] qt_c, qt_p;

   logic [1:0]  mq_c, mq_p;
   logic [31:0] mqt_c, mqt_p;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 CLK = ~CLK;

   dff_ift #(.WIDTH(2), .TAINT_WIDTH(32), .PRECISE(0)) dut_c (
      .CLK(CLK), .RST_N(RST_N), .CLK_t(CLK_t), .RST_N_t(RST_N_t),
      .D(D), .D_t(D_t), .Q(q_c), .Q_t(qt_c)
   );

   dff_ift #(.WIDTH(2), .TAINT_WIDTH(32), .PRECISE(1)) dut_p (
      .CLK(CLK), .RST_N(RST_N), .CLK_t(CLK_t), .RST_N_t(RST_N_t),
      .D(D), .D_t(D_t), .Q(q_p), .Q_t(qt_p)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: reset forces 0 / RST_N_t; a clean edge samples D and merges labels by the mode's rule.
   task automatic cycle();
      logic [1:0]  nq_c, nq_p;
      logic [31:0] nt_c, nt_p;
      if (!RST_N) begin
         nq_c = 2'b00; nq_p = 2'b00;
         nt_c = RST_N_t; nt_p = RST_N_t;
      end else begin
         nq_c = D;
         nq_p = D;
         nt_c = D_t | CLK_t | RST_N_t;
         nt_p = (D == mq_p) ? (mqt_p | D_t) : (D_t | CLK_t | RST_N_t);
      end
      @(posedge CLK);
      #1;
      mq_c = nq_c; mqt_c = nt_c;
      mq_p = nq_p; mqt_p = nt_p;
      check("model_q_c", {30'd0, q_c}, {30'd0, mq_c});
      check("model_qt_c", qt_c, mqt_c);
      check("model_q_p", {30'd0, q_p}, {30'd0, mq_p});
      check("model_qt_p", qt_p, mqt_p);
   endtask

   task automatic drive(input logic [1:0] d, input logic [31:0] dt, input logic [31:0] ct,
                        input logic [31:0] rt);
      @(negedge CLK);
      D = d; D_t = dt; CLK_t = ct; RST_N_t = rt;
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0});
      tbl.push_back('{2'b01, 32'h0, 32'h0, 32'h0, 2'b01, 32'h0});
      tbl.push_back('{2'b10, 32'h0, 32'h0, 32'h0, 2'b10, 32'h0});
      tbl.push_back('{2'b11, 32'h0, 32'h0, 32'h0, 2'b11, 32'h0});
      tbl.push_back('{2'b00, 32'h01, 32'h0, 32'h0, 2'b00, 32'h01});
      tbl.push_back('{2'b01, 32'h02, 32'h0, 32'h0, 2'b01, 32'h02});
      tbl.push_back('{2'b10, 32'h04, 32'h0, 32'h0, 2'b10, 32'h04});
      tbl.push_back('{2'b11, 32'h08, 32'h0, 32'h0, 2'b11, 32'h08});
      tbl.push_back('{2'b11, 32'h10, 32'h0, 32'h0, 2'b11, 32'h10});
      tbl.push_back('{2'b10, 32'h20, 32'h0, 32'h0, 2'b10, 32'h20});
      tbl.push_back('{2'b01, 32'h40, 32'h0, 32'h0, 2'b01, 32'h40});
      tbl.push_back('{2'b00, 32'h80, 32'h0, 32'h0, 2'b00, 32'h80});
      tbl.push_back('{2'b01, 32'h1, 32'h4, 32'h0, 2'b01, 32'h5});
      tbl.push_back('{2'b10, 32'h0, 32'h100, 32'h0, 2'b10, 32'h100});
      tbl.push_back('{2'b11, 32'h10, 32'h0, 32'h8, 2'b11, 32'h18});

      // Asynchronous reset asserted between edges, and Q_t tracking RST_N_t while low.
      #5;
      RST_N_t = 32'h40;
      RST_N = 1'b0;
      #1;
      check("reset_q_c", {30'd0, q_c}, 32'h0);
      check("reset_qt_c", qt_c, 32'h40);
      check("reset_q_p", {30'd0, q_p}, 32'h0);
      RST_N_t = 32'h55;
      #1;
      check("reset_track_qt_c", qt_c, 32'h55);
      check("reset_track_qt_p", qt_p, 32'h55);
      @(negedge CLK);
      RST_N_t = 32'h0;
      cycle();
      @(negedge CLK);
      RST_N = 1'b1;

      // Conservative mode against constant table, precise mode against the model.
      foreach (tbl[i]) begin
         if (i != 0) @(negedge CLK);
         D = tbl[i].d; D_t = tbl[i].dt; CLK_t = tbl[i].ct; RST_N_t = tbl[i].rt;
         cycle();
         check($sformatf("tbl%0d_q", i), {30'd0, q_c}, {30'd0, tbl[i].eq});
         check($sformatf("tbl%0d_qt", i), qt_c, tbl[i].eqt);
      end

      // Precise mode: clock taint blocked while D matches Q, flows once D changes.
      drive(2'b01, 32'h0, 32'h0, 32'h0);
      cycle();
      check("prec_setup_qt", qt_p, 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(2'b01, 32'h0, 32'h100, 32'h0);
         cycle();
         check($sformatf("prec_hold%0d_qt_p", k), qt_p, 32'h0);
         check($sformatf("cons_hold%0d_qt_c", k), qt_c, 32'h100);
      end
      drive(2'b10, 32'h0, 32'h100, 32'h0);
      cycle();
      check("prec_change_qt_p", qt_p, 32'h100);
      check("prec_change_q_p", {30'd0, q_p}, 32'h2);

      // Mid-operation asynchronous reset and release.
      drive(2'b11, 32'h3, 32'h0, 32'h0);
      cycle();
      check("pre_rst_qt_c", qt_c, 32'h3);
      @(negedge CLK);
      #5;
      RST_N_t = 32'h200;
      RST_N = 1'b0;
      #1;
      check("mid_rst_q_c", {30'd0, q_c}, 32'h0);
      check("mid_rst_qt_c", qt_c, 32'h200);
      check("mid_rst_q_p", {30'd0, q_p}, 32'h0);
      check("mid_rst_qt_p", qt_p, 32'h200);
      cycle();
      @(negedge CLK);
      RST_N = 1'b1;
      D = 2'b10; D_t = 32'h1; CLK_t = 32'h4;
      cycle();
      check("rel_q_c", {30'd0, q_c}, 32'h2);
      check("rel_qt_c", qt_c, 32'h205);
      check("rel_qt_p", qt_p, 32'h205);

      // Randomized traffic with occasional reset pulses and repeated D values.
      for (int n = 0; n < 300; n++) begin
         @(negedge CLK);
         if ($urandom_range(0, 1) == 0) D = 2'($urandom_range(0, 3));
         D_t     = ($urandom_range(0, 2) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
         CLK_t   = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
         RST_N_t = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
         RST_N   = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required finish before 200000");
      $fatal(1);
   end

endmodule
